// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the dual-clock FIFO read and write pointer blocks.
// Values are carried zero-extended to MAX_PTR_WIDTH; callers size-cast results back.
package fifo_ptr_pkg;

    localparam int unsigned MAX_PTR_WIDTH = 32;

    // Pointers carry one extra wrap bit above the address.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [MAX_PTR_WIDTH-1:0] width_mask(input int unsigned width);
        return {MAX_PTR_WIDTH{1'b1}} >> (MAX_PTR_WIDTH - width);
    endfunction

    function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(
        input logic [MAX_PTR_WIDTH-1:0] bin,
        input int unsigned              width
    );
        logic [MAX_PTR_WIDTH-1:0] b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(
        input logic [MAX_PTR_WIDTH-1:0] gray,
        input int unsigned              width
    );
        logic [MAX_PTR_WIDTH-1:0] g;
        logic [MAX_PTR_WIDTH-1:0] b;
        g = gray & width_mask(width);
        b = '0;
        b[MAX_PTR_WIDTH-1] = g[MAX_PTR_WIDTH-1];
        // Each binary bit is the XOR of all Gray bits at or above it.
        for (int unsigned i = 1; i < MAX_PTR_WIDTH; i++) begin
            b[MAX_PTR_WIDTH-1-i] = b[MAX_PTR_WIDTH-i] ^ g[MAX_PTR_WIDTH-1-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;

endmodule

// File: rtl/rptr_empty.sv
// Read-side pointer, empty/almost-empty flags, fill count and sticky underflow
// for the dual-clock FIFO; runs entirely in the read clock domain.
module rptr_empty
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                  i_rclk,
    input  logic                  i_rrst,
    input  logic                  i_rinc,
    input  logic [ADDR_WIDTH:0]   i_wptr,
    output logic [ADDR_WIDTH:0]   o_rptr,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic                  o_rempty,
    output logic                  o_raempty,
    output logic [ADDR_WIDTH:0]   o_rcount,
    output logic                  o_runderflow
);

    localparam int unsigned PTR_WIDTH = ptr_width(ADDR_WIDTH);

    logic [PTR_WIDTH-1:0] r_wq2;
    logic [PTR_WIDTH-1:0] w_wq2_bin;
    logic [PTR_WIDTH-1:0] r_rbin;
    logic [PTR_WIDTH-1:0] w_rbnext;
    logic [PTR_WIDTH-1:0] w_rgnext;
    logic [PTR_WIDTH-1:0] w_count_next;
    logic                 w_rinc_ok;
    logic                 w_aempty_next;

    sync_2ff #(
        .WIDTH (PTR_WIDTH)
    ) u_wptr_sync (
        .i_clk (i_rclk),
        .i_rst (i_rrst),
        .i_d   (i_wptr),
        .o_q   (r_wq2)
    );

    always_comb begin
        w_rinc_ok     = i_rinc & ~o_rempty;
        w_rbnext      = r_rbin + PTR_WIDTH'(w_rinc_ok);
        w_rgnext      = PTR_WIDTH'(bin2gray(MAX_PTR_WIDTH'(w_rbnext), PTR_WIDTH));
        w_wq2_bin     = PTR_WIDTH'(gray2bin(MAX_PTR_WIDTH'(r_wq2), PTR_WIDTH));
        // Modulo subtraction keeps the count right across the pointer wrap.
        w_count_next  = w_wq2_bin - w_rbnext;
        w_aempty_next = (MAX_PTR_WIDTH'(w_count_next) <= AEMPTY_THRESH);
    end

    always_ff @(posedge i_rclk) begin
        if (i_rrst) begin
            r_rbin       <= '0;
            o_rptr       <= '0;
            o_rempty     <= 1'b1;
            o_raempty    <= 1'b1;
            o_rcount     <= '0;
            o_runderflow <= 1'b0;
        end else begin
            r_rbin       <= w_rbnext;
            o_rptr       <= w_rgnext;
            o_rempty     <= (w_rgnext == r_wq2);
            o_raempty    <= w_aempty_next;
            o_rcount     <= w_count_next;
            o_runderflow <= o_runderflow | (i_rinc & o_rempty);
        end
    end

    assign o_raddr = r_rbin[ADDR_WIDTH-1:0];

endmodule
